rapcla_err_recover: RTL and testbench

- Checker/recovery stage on the consumer side of the reconfigurable approximate CLA.
- Takes the adder's operands, the approximate SUM/COUT and the ApproxRCON vector that produced them.
- Recovers the carry actually used at each group boundary, detects and attributes carry errors, and emits the exact sum.
- Adapts the ApproxRCON vector for the next window of operations from the per-group error rates it has accumulated.

---
 rtl/rapcla_err_recover_pkg.sv | 43 ++++
 rtl/rapcla_rcon_ctrl.sv | 84 ++++++++
 rtl/rapcla_err_recover.sv | 132 +++++++++++++
 tb/tb_rapcla_err_recover.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/rapcla_err_recover_pkg.sv
// Shared types and helpers for the approximate-CLA checker/recovery stage.
// Group g's carry-out is the speculative carry into group g+1 (or COUT for the last group).
package rapcla_err_recover_pkg;

    localparam int unsigned SIZE      = 16;
    localparam int unsigned GROUPSIZE = 4;
    localparam int unsigned NG        = SIZE / GROUPSIZE;

    typedef struct packed {
        logic [SIZE-1:0] a;
        logic [SIZE-1:0] b;
        logic            cin;
        logic [SIZE-1:0] sum_approx;
        logic            cout_approx;
        logic [NG-1:0]   rcon_used;
    } op_t;

    typedef struct packed {
        logic [SIZE-1:0] sum_exact;
        logic            cout_exact;
        logic            err_flag;
        logic [NG-1:0]   group_err;
    } res_t;

    // True carry out of every group of a + b + cin, element g = carry leaving group g.
    function automatic logic [NG-1:0] boundary_carries(input logic [SIZE-1:0] a,
                                                       input logic [SIZE-1:0] b,
                                                       input logic            cin);
        logic [NG-1:0] co;
        logic          carry;
        co    = '0;
        carry = cin;
        for (int unsigned g = 0; g < NG; g++) begin
            for (int unsigned j = 0; j < GROUPSIZE; j++) begin
                carry = (a[g*GROUPSIZE+j] & b[g*GROUPSIZE+j])
                      | (carry & (a[g*GROUPSIZE+j] ^ b[g*GROUPSIZE+j]));
            end
            co[g] = carry;
        end
        return co;
    endfunction

endpackage

// File: rtl/rapcla_rcon_ctrl.sv
// Window-based error accounting and ApproxRCON adaptation, advanced only on output handshakes.
module rapcla_rcon_ctrl
    import rapcla_err_recover_pkg::*;
#(
    parameter int unsigned WIN_OPS = 64,
    parameter int unsigned THRESH  = 4,
    parameter int unsigned CNTW    = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            hs,
    input  logic [NG-1:0]   group_err,
    input  logic            err_flag,
    input  logic            cfg_adapt,
    input  logic [NG-1:0]   cfg_rcon,
    output logic [NG-1:0]   rcon_next,
    output logic            win_done,
    output logic [CNTW-1:0] total_err
);

    localparam logic [CNTW-1:0] LAST_OP  = CNTW'(WIN_OPS - 1);
    localparam logic [CNTW:0]   THRESH_W = (CNTW+1)'(THRESH);

    logic [CNTW-1:0] op_cnt_q, op_cnt_d;
    logic [CNTW-1:0] err_cnt_q [NG];
    logic [CNTW-1:0] err_cnt_d [NG];
    logic [NG-1:0]   rcon_q, rcon_d;
    logic            win_done_q, win_done_d;
    logic [CNTW-1:0] total_err_q, total_err_d;

    // The closing handshake's own blame counts toward the decision, then the window restarts clean.
    always_comb begin
        op_cnt_d    = op_cnt_q;
        err_cnt_d   = err_cnt_q;
        rcon_d      = rcon_q;
        win_done_d  = 1'b0;
        total_err_d = total_err_q;
        if (hs) begin
            if (err_flag && (total_err_q != '1)) begin
                total_err_d = total_err_q + 1'b1;
            end
            if (op_cnt_q == LAST_OP) begin
                op_cnt_d   = '0;
                win_done_d = 1'b1;
                for (int unsigned g = 0; g < NG; g++) begin
                    rcon_d[g]    = cfg_adapt
                                 ? (({1'b0, err_cnt_q[g]} + (CNTW+1)'(group_err[g])) <= THRESH_W)
                                 : cfg_rcon[g];
                    err_cnt_d[g] = '0;
                end
            end else begin
                op_cnt_d = op_cnt_q + 1'b1;
                for (int unsigned g = 0; g < NG; g++) begin
                    if (group_err[g] && (err_cnt_q[g] != '1)) begin
                        err_cnt_d[g] = err_cnt_q[g] + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_cnt_q    <= '0;
            rcon_q      <= '1;
            win_done_q  <= 1'b0;
            total_err_q <= '0;
            for (int unsigned g = 0; g < NG; g++) begin
                err_cnt_q[g] <= '0;
            end
        end else begin
            op_cnt_q    <= op_cnt_d;
            rcon_q      <= rcon_d;
            win_done_q  <= win_done_d;
            total_err_q <= total_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign rcon_next = rcon_q;
    assign win_done  = win_done_q;
    assign total_err = total_err_q;

endmodule

// File: rtl/rapcla_err_recover.sv
// Two-stage checker for the approximate CLA: exact sum, carry-error attribution,
// and adaptive ApproxRCON selection for the next window.
module rapcla_err_recover
    import rapcla_err_recover_pkg::*;
#(
    parameter int unsigned WIN_OPS = 64,
    parameter int unsigned THRESH  = 4,
    parameter int unsigned CNTW    = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [SIZE-1:0] A,
    input  logic [SIZE-1:0] B,
    input  logic            CIN,
    input  logic [SIZE-1:0] SUM_APPROX,
    input  logic            COUT_APPROX,
    input  logic [NG-1:0]   RCON_USED,
    input  logic            cfg_adapt,
    input  logic [NG-1:0]   cfg_rcon,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SIZE-1:0] SUM_EXACT,
    output logic            COUT_EXACT,
    output logic            ERR_FLAG,
    output logic [NG-1:0]   GROUP_ERR,
    output logic [NG-1:0]   RCON_NEXT,
    output logic            win_done,
    output logic [CNTW-1:0] total_err
);

    if (SIZE % GROUPSIZE != 0) begin : g_chk_size
        $error("SIZE must be a multiple of GROUPSIZE");
    end
    if (WIN_OPS < 2) begin : g_chk_win
        $error("WIN_OPS must be at least 2");
    end
    if (WIN_OPS >= (1 << CNTW)) begin : g_chk_cntw
        $error("CNTW too narrow for WIN_OPS");
    end

    op_t         s1_op_q, s1_op_d;
    logic        s1_valid_q, s1_valid_d;
    res_t        s2_res_q, s2_res_d;
    logic        s2_valid_q, s2_valid_d;
    res_t        res_c;
    logic [SIZE:0]   exact_c;
    logic [NG-1:0]   co_exact_c, co_used_c;
    logic        advance_c;

    assign advance_c = !s2_valid_q || out_ready;
    assign in_ready  = !(s1_valid_q && s2_valid_q && !out_ready);

    // Recover the carry the approximate adder actually used at each group boundary.
    always_comb begin
        exact_c    = {1'b0, s1_op_q.a} + {1'b0, s1_op_q.b} + (SIZE+1)'(s1_op_q.cin);
        co_exact_c = boundary_carries(s1_op_q.a, s1_op_q.b, s1_op_q.cin);
        co_used_c  = '0;
        for (int unsigned g = 0; g < NG - 1; g++) begin
            co_used_c[g] = s1_op_q.sum_approx[(g+1)*GROUPSIZE]
                         ^ s1_op_q.a[(g+1)*GROUPSIZE] ^ s1_op_q.b[(g+1)*GROUPSIZE];
        end
        co_used_c[NG-1]  = s1_op_q.cout_approx;
        res_c.sum_exact  = exact_c[SIZE-1:0];
        res_c.cout_exact = exact_c[SIZE];
        res_c.err_flag   = ({s1_op_q.cout_approx, s1_op_q.sum_approx} != exact_c);
        res_c.group_err  = s1_op_q.rcon_used & (co_used_c ^ co_exact_c);
    end

    // Whole-pipeline stall: nothing moves while the output is held.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_op_d    = s1_op_q;
        s2_valid_d = s2_valid_q;
        s2_res_d   = s2_res_q;
        if (advance_c) begin
            s2_valid_d = s1_valid_q;
            s1_valid_d = 1'b0;
            if (s1_valid_q) begin
                s2_res_d = res_c;
            end
        end
        if (in_valid && in_ready) begin
            s1_valid_d          = 1'b1;
            s1_op_d.a           = A;
            s1_op_d.b           = B;
            s1_op_d.cin         = CIN;
            s1_op_d.sum_approx  = SUM_APPROX;
            s1_op_d.cout_approx = COUT_APPROX;
            s1_op_d.rcon_used   = RCON_USED;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_res_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_op_q    <= s1_op_d;
            s2_valid_q <= s2_valid_d;
            s2_res_q   <= s2_res_d;
        end
    end

    assign out_valid  = s2_valid_q;
    assign SUM_EXACT  = s2_res_q.sum_exact;
    assign COUT_EXACT = s2_res_q.cout_exact;
    assign ERR_FLAG   = s2_res_q.err_flag;
    assign GROUP_ERR  = s2_res_q.group_err;

    rapcla_rcon_ctrl #(
        .WIN_OPS (WIN_OPS),
        .THRESH  (THRESH),
        .CNTW    (CNTW)
    ) u_rcon_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .hs        (s2_valid_q && out_ready),
        .group_err (s2_res_q.group_err),
        .err_flag  (s2_res_q.err_flag),
        .cfg_adapt (cfg_adapt),
        .cfg_rcon  (cfg_rcon),
        .rcon_next (RCON_NEXT),
        .win_done  (win_done),
        .total_err (total_err)
    );

endmodule

// File: tb/tb_rapcla_err_recover.sv
// Directed bench for rapcla_err_recover with an 8-operation window and threshold 2.
module tb_rapcla_err_recover;
    import rapcla_err_recover_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, CIN, COUT_APPROX, cfg_adapt;
    logic        out_valid, out_ready, COUT_EXACT, ERR_FLAG, win_done;
    logic [15:0] A, B, SUM_APPROX, SUM_EXACT;
    logic [3:0]  RCON_USED, cfg_rcon, GROUP_ERR, RCON_NEXT;
    logic [7:0]  total_err;
    int          total = 0;
    int          bad   = 0;
    int          wd_total = 0;
    int          wd_base;

    always #5 clk = ~clk;

    always @(negedge clk) if (win_done === 1'b1) wd_total <= wd_total + 1;

    rapcla_err_recover #(.WIN_OPS(8), .THRESH(2), .CNTW(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .CIN(CIN), .SUM_APPROX(SUM_APPROX), .COUT_APPROX(COUT_APPROX),
        .RCON_USED(RCON_USED), .cfg_adapt(cfg_adapt), .cfg_rcon(cfg_rcon),
        .out_valid(out_valid), .out_ready(out_ready), .SUM_EXACT(SUM_EXACT),
        .COUT_EXACT(COUT_EXACT), .ERR_FLAG(ERR_FLAG), .GROUP_ERR(GROUP_ERR),
        .RCON_NEXT(RCON_NEXT), .win_done(win_done), .total_err(total_err)
    );

    task step;
        @(posedge clk); #1;
    endtask

    task apply(input logic [15:0] a, input logic [15:0] b, input logic ci,
               input logic [15:0] sa, input logic ca, input logic [3:0] rc);
        A = a; B = b; CIN = ci; SUM_APPROX = sa; COUT_APPROX = ca; RCON_USED = rc;
        in_valid = 1'b1;
    endtask

    // 0x1234 + 0x0101 = 0x1335 has no internal carries; flipping SUM bit 4/8 blames group bit 0/1.
    task feed_op(input logic [15:0] flip);
        apply(16'h1234, 16'h0101, 1'b0, 16'h1335 ^ flip, 1'b0, 4'hF);
        step;
        in_valid = 1'b0;
    endtask

    task drain;
        in_valid = 1'b0;
        repeat (4) step;
    endtask

    task do_reset;
        rst_n = 1'b0; in_valid = 1'b0;
        step; step;
        rst_n = 1'b1;
    endtask

    task test_reset;
        out_ready = 1'b1;
        do_reset;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        total++; if ({COUT_EXACT, SUM_EXACT, ERR_FLAG, GROUP_ERR} !== 22'h0) begin bad++;
            $display("FAIL rst_results got=%h/%b/%b/%b exp=0", SUM_EXACT, COUT_EXACT, ERR_FLAG, GROUP_ERR); end
        total++; if (RCON_NEXT !== 4'hF) begin bad++; $display("FAIL rst_rcon got=%b exp=1111", RCON_NEXT); end
        total++; if (win_done !== 1'b0 || total_err !== 8'd0) begin bad++;
            $display("FAIL rst_ctrl got wd=%b te=%0d exp wd=0 te=0", win_done, total_err); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    endtask

    task test_basic;
        apply(16'h000F, 16'h0001, 1'b0, 16'h0000, 1'b0, 4'b1111);
        step;
        apply(16'h000F, 16'h0001, 1'b0, 16'h0010, 1'b0, 4'b0000);
        step;
        total++; if (out_valid !== 1'b1 || SUM_EXACT !== 16'h0010 || COUT_EXACT !== 1'b0) begin bad++;
            $display("FAIL basic1_sum got v=%b sum=%h c=%b exp v=1 sum=0010 c=0", out_valid, SUM_EXACT, COUT_EXACT); end
        total++; if (ERR_FLAG !== 1'b1 || GROUP_ERR !== 4'b0001) begin bad++;
            $display("FAIL basic1_err got err=%b ge=%b exp err=1 ge=0001", ERR_FLAG, GROUP_ERR); end
        apply(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 4'b1111);
        step;
        total++; if (out_valid !== 1'b1 || SUM_EXACT !== 16'h0010 || ERR_FLAG !== 1'b0 || GROUP_ERR !== 4'b0000) begin bad++;
            $display("FAIL basic2 got v=%b sum=%h err=%b ge=%b exp v=1 sum=0010 err=0 ge=0000", out_valid, SUM_EXACT, ERR_FLAG, GROUP_ERR); end
        in_valid = 1'b0;
        step;
        total++; if (out_valid !== 1'b1 || SUM_EXACT !== 16'h0000 || COUT_EXACT !== 1'b1 || ERR_FLAG !== 1'b0 || GROUP_ERR !== 4'b0000) begin bad++;
            $display("FAIL basic3_wrap got v=%b sum=%h c=%b err=%b ge=%b exp v=1 sum=0000 c=1 err=0 ge=0000",
                     out_valid, SUM_EXACT, COUT_EXACT, ERR_FLAG, GROUP_ERR); end
        drain;
    endtask

    task test_back_to_back;
        logic [21:0] expq[$];
        logic [21:0] got_w, prev_w;
        logic [15:0] a, b, sa;
        logic [16:0] ex;
        logic        ci, fl, prev_stall, exp_rdy;
        int          sent, got, occ;
        sent = 0; got = 0; occ = 0; prev_stall = 1'b0; prev_w = '0;
        for (int cyc = 0; cyc < 200 && got < 10; cyc++) begin
            out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            a  = 16'(sent * 32'h1111);
            b  = 16'h0F0F ^ 16'(sent);
            ci = sent[0];
            fl = sent[0];
            ex = {1'b0, a} + {1'b0, b} + 17'(ci);
            sa = ex[15:0] ^ (fl ? 16'h0010 : 16'h0000);
            if (sent < 10) apply(a, b, ci, sa, ex[16], 4'hF);
            else in_valid = 1'b0;
            #1;
            got_w   = {COUT_EXACT, SUM_EXACT, ERR_FLAG, GROUP_ERR};
            exp_rdy = !(occ == 2 && !out_ready);
            total++; if (in_ready !== exp_rdy) begin bad++;
                $display("FAIL b2b_in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, exp_rdy); end
            if (prev_stall) begin
                total++; if (out_valid !== 1'b1 || got_w !== prev_w) begin bad++;
                    $display("FAIL b2b_stable cyc=%0d got=%h exp=%h", cyc, got_w, prev_w); end
            end
            if (out_valid && out_ready) begin
                total++;
                if (expq.size() == 0) begin bad++; $display("FAIL b2b_extra cyc=%0d got=%h exp=none", cyc, got_w); end
                else begin
                    if (got_w !== expq[0]) begin bad++;
                        $display("FAIL b2b_data cyc=%0d got=%h exp=%h", cyc, got_w, expq[0]); end
                    void'(expq.pop_front());
                end
                got++; occ--;
            end
            if (in_valid && in_ready) begin
                expq.push_back({ex[16], ex[15:0], fl, 3'b000, fl});
                sent++; occ++;
            end
            prev_stall = out_valid && !out_ready;
            prev_w     = got_w;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        total++; if (got != 10 || sent != 10) begin bad++;
            $display("FAIL b2b_count got sent=%0d recv=%0d exp 10/10", sent, got); end
        drain;
    endtask

    task test_adapt;
        logic [15:0] flips [8];
        flips = '{16'h0010, 16'h0010, 16'h0000, 16'h0100, 16'h0100, 16'h0000, 16'h0000, 16'h0010};
        do_reset;
        cfg_adapt = 1'b1; cfg_rcon = 4'b0000;
        wd_base = wd_total;
        for (int i = 0; i < 8; i++) feed_op(flips[i]);
        total++; if (RCON_NEXT !== 4'b1111 || wd_total != wd_base) begin bad++;
            $display("FAIL adapt_preclose got rcon=%b wd=%0d exp rcon=1111 wd=0", RCON_NEXT, wd_total - wd_base); end
        drain;
        total++; if (RCON_NEXT !== 4'b1110) begin bad++; $display("FAIL adapt_rcon got=%b exp=1110", RCON_NEXT); end
        total++; if (wd_total - wd_base != 1) begin bad++; $display("FAIL adapt_win_done got=%0d exp=1", wd_total - wd_base); end
        total++; if (total_err !== 8'd5) begin bad++; $display("FAIL adapt_total_err got=%0d exp=5", total_err); end
    endtask

    task test_static;
        cfg_adapt = 1'b0; cfg_rcon = 4'b0101;
        wd_base = wd_total;
        for (int i = 0; i < 8; i++) feed_op(16'h0000);
        drain;
        total++; if (RCON_NEXT !== 4'b0101 || wd_total - wd_base != 1) begin bad++;
            $display("FAIL static_first got rcon=%b wd=%0d exp rcon=0101 wd=1", RCON_NEXT, wd_total - wd_base); end
        for (int i = 0; i < 4; i++) feed_op(16'h0000);
        drain;
        cfg_rcon = 4'b0011;
        step;
        total++; if (RCON_NEXT !== 4'b0101) begin bad++; $display("FAIL static_mid got=%b exp=0101", RCON_NEXT); end
        for (int i = 0; i < 4; i++) feed_op(16'h0000);
        drain;
        total++; if (RCON_NEXT !== 4'b0011 || wd_total - wd_base != 2) begin bad++;
            $display("FAIL static_close got rcon=%b wd=%0d exp rcon=0011 wd=2", RCON_NEXT, wd_total - wd_base); end
    endtask

    task test_reset_midflight;
        cfg_adapt = 1'b1;
        for (int i = 0; i < 3; i++) feed_op(16'h0100);
        drain;
        out_ready = 1'b0;
        feed_op(16'h0000);
        feed_op(16'h0000);
        total++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin bad++;
            $display("FAIL full_stall got rdy=%b v=%b exp rdy=0 v=1", in_ready, out_valid); end
        rst_n = 1'b0;
        step;
        rst_n = 1'b1; out_ready = 1'b1;
        total++; if (out_valid !== 1'b0 || RCON_NEXT !== 4'b1111 || total_err !== 8'd0) begin bad++;
            $display("FAIL midrst_state got v=%b rcon=%b te=%0d exp v=0 rcon=1111 te=0", out_valid, RCON_NEXT, total_err); end
        wd_base = wd_total;
        for (int i = 0; i < 7; i++) feed_op(16'h0010);
        drain;
        total++; if (RCON_NEXT !== 4'b1111 || wd_total != wd_base) begin bad++;
            $display("FAIL midrst_no_early_close got rcon=%b wd=%0d exp rcon=1111 wd=0", RCON_NEXT, wd_total - wd_base); end
        feed_op(16'h0010);
        drain;
        total++; if (RCON_NEXT !== 4'b1110 || wd_total - wd_base != 1 || total_err !== 8'd8) begin bad++;
            $display("FAIL midrst_window got rcon=%b wd=%0d te=%0d exp rcon=1110 wd=1 te=8",
                     RCON_NEXT, wd_total - wd_base, total_err); end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; cfg_adapt = 1'b1; cfg_rcon = 4'h0;
        A = '0; B = '0; CIN = 1'b0; SUM_APPROX = '0; COUT_APPROX = 1'b0; RCON_USED = '0;
        test_reset;
        test_basic;
        test_back_to_back;
        test_adapt;
        test_static;
        test_reset_midflight;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
